// File: rtl/ifmap_bram_loader.sv
// Serial-to-banked write stage for the ifmap BRAM array: fills banks in order,
// cfg_len words per bank starting at cfg_base_addr, one stream word per cycle.
module ifmap_bram_loader #(
    parameter int DW         = 16,
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BANK_W     = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             cfg_base_addr,
    input  logic [ADDR_WIDTH:0]               cfg_len,
    input  logic [BANK_W:0]                   cfg_num_banks,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DW-1:0]                     s_data,
    input  logic                              s_last,
    output logic [NUM_BRAMS-1:0]              if_we,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0]   if_addr_wr_flat,
    output logic [NUM_BRAMS*DW-1:0]           if_din_flat,
    output logic                              busy,
    output logic                              done,
    output logic                              err_short,
    output logic [ADDR_WIDTH+BANK_W:0]        words_written
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_next;

    logic [ADDR_WIDTH-1:0]       r_base;
    logic [ADDR_WIDTH:0]         r_len;
    logic [BANK_W:0]             r_num_banks;
    logic [ADDR_WIDTH:0]         r_word_cnt;
    logic [BANK_W-1:0]           r_bank_cnt;
    logic [NUM_BRAMS-1:0]        r_if_we;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [DW-1:0]               r_din;
    logic                        r_done;
    logic                        r_err_short;
    logic [ADDR_WIDTH+BANK_W:0]  r_words_written;

    logic                        w_start;
    logic                        w_hs;
    logic                        w_last_word;
    logic                        w_complete;
    logic                        w_final;
    logic [BANK_W:0]             w_num_banks;

    assign w_start     = start & (r_state == S_IDLE);
    assign w_hs        = s_valid & (r_state == S_LOAD);
    assign w_last_word = (r_word_cnt == r_len - (ADDR_WIDTH+1)'(1));
    assign w_complete  = w_last_word &
                         ({1'b0, r_bank_cnt} == r_num_banks - (BANK_W+1)'(1));
    assign w_final     = w_hs & (w_complete | s_last);

    // Bank count of 0 means one bank; anything past the array is clamped.
    always_comb begin
        w_num_banks = cfg_num_banks;
        if (cfg_num_banks == '0)
            w_num_banks = (BANK_W+1)'(1);
        else if (cfg_num_banks > (BANK_W+1)'(NUM_BRAMS))
            w_num_banks = (BANK_W+1)'(NUM_BRAMS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start)   w_state_next = (cfg_len == '0) ? S_DONE : S_LOAD;
            S_LOAD: if (w_final) w_state_next = S_DONE;
            S_DONE:              w_state_next = S_IDLE;
            default:             w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base          <= '0;
            r_len           <= '0;
            r_num_banks     <= '0;
            r_word_cnt      <= '0;
            r_bank_cnt      <= '0;
            r_if_we         <= '0;
            r_addr          <= '0;
            r_din           <= '0;
            r_done          <= 1'b0;
            r_err_short     <= 1'b0;
            r_words_written <= '0;
        end else begin
            r_if_we <= '0;
            r_done  <= 1'b0;
            if (w_start) begin
                r_base          <= cfg_base_addr;
                r_len           <= cfg_len;
                r_num_banks     <= w_num_banks;
                r_word_cnt      <= '0;
                r_bank_cnt      <= '0;
                r_words_written <= '0;
                r_err_short     <= 1'b0;
                r_done          <= (cfg_len == '0);
            end
            if (w_hs) begin
                r_if_we         <= {{(NUM_BRAMS-1){1'b0}}, 1'b1} << r_bank_cnt;
                r_addr          <= r_base + r_word_cnt[ADDR_WIDTH-1:0];
                r_din           <= s_data;
                r_words_written <= r_words_written + (ADDR_WIDTH+BANK_W+1)'(1);
                if (w_last_word) begin
                    r_word_cnt <= '0;
                    r_bank_cnt <= r_bank_cnt + BANK_W'(1);
                end else begin
                    r_word_cnt <= r_word_cnt + (ADDR_WIDTH+1)'(1);
                end
            end
            if (w_final) begin
                r_done <= 1'b1;
                if (!w_complete)
                    r_err_short <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BRAMS; gi++) begin : g_lane
            assign if_addr_wr_flat[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_addr;
            assign if_din_flat[gi*DW +: DW]                     = r_din;
        end
    endgenerate

    assign s_ready       = (r_state == S_LOAD);
    assign busy          = (r_state != S_IDLE);
    assign if_we         = r_if_we;
    assign done          = r_done;
    assign err_short     = r_err_short;
    assign words_written = r_words_written;

endmodule

// File: tb/tb_ifmap_bram_loader.sv
// Randomized directed bench for ifmap_bram_loader; expected writes come from
// the load description (word index -> bank, offset, wrapped address).
module tb_ifmap_bram_loader;

    localparam int DW = 16;
    localparam int NB = 16;
    localparam int AW = 10;
    localparam int BW = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [AW-1:0]        cfg_base_addr = '0;
    logic [AW:0]          cfg_len = '0;
    logic [BW:0]          cfg_num_banks = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [DW-1:0]        s_data = '0;
    logic                 s_last = 1'b0;
    logic [NB-1:0]        if_we;
    logic [NB*AW-1:0]     if_addr_wr_flat;
    logic [NB*DW-1:0]     if_din_flat;
    logic                 busy;
    logic                 done;
    logic                 err_short;
    logic [AW+BW:0]       words_written;

    int checks = 0;
    int errors = 0;

    ifmap_bram_loader #(.DW(DW), .NUM_BRAMS(NB), .ADDR_WIDTH(AW), .BANK_W(BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_num_banks(cfg_num_banks),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .if_we(if_we), .if_addr_wr_flat(if_addr_wr_flat), .if_din_flat(if_din_flat),
        .busy(busy), .done(done), .err_short(err_short), .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*AW-1:0] rep_addr(input int a);
        logic [NB*AW-1:0] r;
        for (int l = 0; l < NB; l++) r[l*AW +: AW] = AW'(a);
        return r;
    endfunction

    function automatic logic [NB*DW-1:0] rep_din(input logic [DW-1:0] d);
        logic [NB*DW-1:0] r;
        for (int l = 0; l < NB; l++) r[l*DW +: DW] = d;
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_we"}, if_we, 0);
        chk({tag, "_ready"}, s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_short, 0);
        chk({tag, "_words"}, words_written, 0);
        chk({tag, "_addr"}, if_addr_wr_flat, 0);
        chk({tag, "_din"}, if_din_flat, 0);
    endtask

    // One load: drive start, stream words, compare every cycle against the model.
    task automatic do_load(input int base, input int len, input int nbc, input int last_idx,
                           input bit bubbles, input bit mid_start, input int abort_after);
        int nb, total, n_exp, i, budget;
        bit err_exp;
        logic [DW-1:0] d;
        logic [NB-1:0] exp_we;
        nb      = (nbc == 0) ? 1 : ((nbc > NB) ? NB : nbc);
        total   = len * nb;
        n_exp   = (last_idx >= 0 && last_idx < total) ? last_idx + 1 : total;
        err_exp = (n_exp < total);
        $display("load base=%0d len=%0d banks=%0d last=%0d bubbles=%0d words_expected=%0d",
                 base, len, nbc, last_idx, bubbles, n_exp);

        @(negedge clk);
        start = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        cfg_base_addr = AW'(base); cfg_len = (AW+1)'(len); cfg_num_banks = (BW+1)'(nbc);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_base_addr = AW'($urandom); cfg_len = (AW+1)'($urandom); cfg_num_banks = (BW+1)'($urandom);
        chk("start_we", if_we, 0);
        chk("start_busy", busy, 1);
        chk("start_err_clear", err_short, 0);
        chk("start_words", words_written, 0);
        chk("start_done", done, (len == 0));
        if (len == 0) begin
            @(posedge clk); #1;
            chk("zlen_done_after", done, 0);
            chk("zlen_busy_after", busy, 0);
            chk("zlen_we", if_we, 0);
            return;
        end

        i = 0; budget = 0;
        while (i < n_exp && budget < 40000) begin
            @(negedge clk);
            budget++;
            s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            d = DW'($urandom);
            s_data = d;
            s_last = (i == last_idx);
            if (mid_start) start = ($urandom_range(0, 99) == 0);
            chk("s_ready_load", s_ready, 1);
            @(posedge clk); #1;
            start = 1'b0;
            if (s_valid) begin
                exp_we = '0;
                exp_we[i / len] = 1'b1;
                chk("we", if_we, exp_we);
                chk("addr", if_addr_wr_flat, rep_addr((base + i % len) % (1 << AW)));
                chk("din", if_din_flat, rep_din(d));
                chk("words", words_written, i + 1);
                chk("done", done, (i == n_exp - 1));
                i++;
                if (abort_after > 0 && i == abort_after) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                    #2 rst_n = 1'b0;
                    #1 check_idle_outputs("reset_mid");
                    @(posedge clk); #1;
                    check_idle_outputs("reset_hold");
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end else begin
                chk("gap_we", if_we, 0);
                chk("gap_done", done, 0);
            end
        end
        chk("handshakes_in_budget", i, n_exp);
        chk("err_at_done", err_short, err_exp);

        @(negedge clk);
        s_valid = 1'b1; s_last = 1'b0;
        chk("ready_after_final", s_ready, 0);
        chk("busy_in_done", busy, 1);
        @(posedge clk); #1;
        chk("we_after_final", if_we, 0);
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("words_final", words_written, n_exp);
        chk("err_sticky", err_short, err_exp);
        s_valid = 1'b0;
    endtask

    initial begin
        int len, nbc, last;
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_load(0, 4, 2, 7, 1'b0, 1'b0, 0);        // basic fill, s_last on word 8
        do_load(0, 4, 2, 7, 1'b1, 1'b0, 0);        // bubbles
        do_load(0, 4, 2, 2, 1'b0, 1'b0, 0);        // early s_last on word 3
        do_load(0, 4, 2, -1, 1'b0, 1'b0, 0);       // err_short cleared by start
        do_load(1022, 4, 1, -1, 1'b0, 1'b0, 0);    // address wrap
        do_load(5, 0, 3, -1, 1'b0, 1'b0, 0);       // zero length
        do_load(7, 3, 0, -1, 1'b0, 1'b0, 0);       // zero banks -> one
        do_load(100, 2, 25, -1, 1'b1, 1'b0, 0);    // clamp to all banks

        for (int k = 0; k < 6; k++) begin
            len  = $urandom_range(1, 40);
            nbc  = $urandom_range(0, 31);
            last = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, 300);
            do_load($urandom_range(0, 1023), len, nbc, last, 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        do_load(0, 1024, 16, 16383, 1'b0, 1'b1, 0);  // full array, stray starts ignored
        do_load(0, 8, 2, -1, 1'b0, 1'b0, 5);         // reset after 5 words
        do_load(0, 8, 2, -1, 1'b1, 1'b0, 0);         // clean load after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifmap_bram_loader.md
Name: ifmap_bram_loader

Overview:
- Upstream write stage for the 16-bank ifmap BRAM array.
- Accepts a serial valid/ready stream of DW-bit ifmap samples from the DMA/input FIFO.
- Fills banks sequentially: bank 0 first, then bank 1, and so on. Each bank receives cfg_len words starting at cfg_base_addr.
- Drives the per-bank write enable, write address and write data buses of the ifmap BRAM top.

Parameters:
DW, 16, sample width in bits
NUM_BRAMS, 16, number of ifmap banks
ADDR_WIDTH, 10, BRAM address width
BANK_W, 4, width of bank index (clog2 NUM_BRAMS)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; latches cfg_* and begins a load (honoured only in IDLE)
cfg_base_addr  in  ADDR_WIDTH  first write address in every bank
cfg_len  in  ADDR_WIDTH+1  words per bank, 0..DEPTH
cfg_num_banks  in  BANK_W+1  banks to fill, 1..NUM_BRAMS (0 treated as 1)
s_valid  in  1  stream sample valid
s_ready  out  1  loader can accept sample
s_data  in  DW  signed sample
s_last  in  1  final sample of stream
if_we  out  NUM_BRAMS  one-hot bank write enable
if_addr_wr_flat  out  NUM_BRAMS*ADDR_WIDTH  write address, same value replicated to every lane
if_din_flat  out  NUM_BRAMS*DW  write data, same value replicated to every lane
busy  out  1  high in LOAD and DONE
done  out  1  one-cycle completion pulse
err_short  out  1  sticky: s_last arrived before the expected word count
words_written  out  ADDR_WIDTH+BANK_W+1  count of words written in the current or last load

Behaviour:
- Reset values: all outputs 0. State is IDLE and counters are cleared. Reset mid-load aborts immediately; no further if_we is asserted.
- States: IDLE -> LOAD on start. LOAD -> DONE on the final handshake. DONE -> IDLE after one cycle.
- Final handshake (either condition):
  - word_cnt==cfg_len-1 and bank_cnt==num_banks-1, or
  - s_last=1.
- start when cfg_len==0: go directly IDLE -> DONE; no writes; done pulses on the next cycle.
- start in LOAD or DONE: ignored.
- Latching and clears on start: cfg values are latched; word_cnt, bank_cnt, words_written and err_short are cleared.
- s_ready: 1 exactly when state==LOAD. It is combinational from state and independent of s_valid.
- Handshake: s_valid & s_ready at rising edge t.
- Write timing for a handshake at edge t, all outputs registered, so visible in the cycle after t:
  - if_we = 1<<bank_cnt
  - address = (cfg_base_addr+word_cnt) mod 2^ADDR_WIDTH, which wraps silently
  - din = s_data
  - With no handshake, if_we=0. Address and data hold their last values.
- Counter advance on each handshake: word_cnt increments. When word_cnt reaches cfg_len-1, word_cnt resets to 0 and bank_cnt increments. words_written increments on every handshake.
- done: registered pulse, high in the same cycle as the final word's if_we.
- err_short: set on a final handshake caused by s_last when the count is not complete. Cleared only by the next accepted start or by reset.
- s_last on exactly the expected final word: normal completion, err_short stays 0.
- Stream words arriving after completion: not accepted (s_ready=0).
- Throughput: one word per cycle with s_valid held high. Back-pressure comes only from the state machine.
- cfg_num_banks greater than NUM_BRAMS: clamp to NUM_BRAMS.

Test Plan:
- Basic fill:
  - Stimulus: cfg_base_addr=0, cfg_len=4, cfg_num_banks=2, continuous s_valid with data 1..8, s_last on 8.
  - Response: if_we=0x0001 at addr 0..3 with din 1..4, then 0x0002 at addr 0..3 with din 5..8. done in the cycle of the 8th write; words_written=8; err_short=0.
- Bubbles:
  - Stimulus: same configuration, s_valid toggling 1/0.
  - Response: identical write sequence; if_we=0 in gap cycles; done timing follows the last accepted word.
- Early termination:
  - Stimulus: cfg_len=4, banks=2, s_last on word 3.
  - Response: 3 writes to bank 0, then done and err_short=1. s_ready=0 afterwards; err_short clears on the next start.
- Wrap and zero length:
  - Stimulus A: cfg_base_addr=1022, cfg_len=4, banks=1. Response: addresses 1022, 1023, 0, 1.
  - Stimulus B: cfg_len=0. Response: no if_we; done 1 cycle after start.
- Full array:
  - Stimulus: cfg_len=1024, banks=16, 16384 words.
  - Response: each one-hot bank 0..15 receives 1024 writes; words_written=16384; a start pulse mid-load is ignored.
- Reset mid-load:
  - Stimulus: assert rst_n=0 after 5 words.
  - Response: all outputs 0 asynchronously, state IDLE; a following start runs a clean load from word 0.
